pipe_ctrl_tracker: RTL

- Carries decoded control bits from the decode stage down the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Returns the stage-tagged register numbers and write enables that the forwarding and hazard logic consume. It is the receiving end of the decode controller's Final* outputs and the source of its ID_EX_*, EX_MEM_* and MEM_WB_* inputs.
- Adds saturating event counters (stalls, flushes, forwards, retired instructions) for performance debug.

---
 rtl/pipe_ctrl_tracker.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_tracker.sv
// Carries decoded control from decode through the ID/EX, EX/MEM and MEM/WB registers,
// exposing stage-tagged register numbers for forwarding/hazard logic plus saturating event counters.
module pipe_ctrl_tracker #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Freeze,
  input  logic             CntClear,
  input  logic             ID_Valid,
  input  logic             FinalALUSrc,
  input  logic             FinalRegDst,
  input  logic             FinalMemWrite,
  input  logic             FinalMemRead,
  input  logic             FinalMemToReg,
  input  logic             FinalRegWrite,
  input  logic [2:0]       FinalALUOperation,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic [4:0]       ID_Rd,
  input  logic             IF_ID_Write,
  input  logic             IF_Flush,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  output logic             EX_ALUSrc,
  output logic             EX_RegDst,
  output logic [2:0]       EX_ALUOperation,
  output logic [4:0]       ID_EX_Rs,
  output logic [4:0]       ID_EX_Rt,
  output logic [4:0]       ID_EX_Rd,
  output logic             ID_EX_MemRead,
  output logic             EX_MEM_RegWrite,
  output logic             EX_MEM_MemWrite,
  output logic             EX_MEM_MemRead,
  output logic             EX_MEM_MemToReg,
  output logic [4:0]       EX_MEM_Rd,
  output logic             MEM_WB_RegWrite,
  output logic             MEM_WB_MemToReg,
  output logic [4:0]       MEM_WB_Rd,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [CNT_W-1:0] FwdCount,
  output logic [CNT_W-1:0] RetiredCount
);

  localparam int unsigned RW = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic          idex_valid_q, exmem_valid_q, memwb_valid_q;
  logic          idex_memwrite_q, idex_memtoreg_q, idex_regwrite_q;
  logic          id_valid_c;
  logic [RW-1:0] ex_dst_c;
  logic [CNT_W-1:0] stall_q, flush_q, fwd_q, ret_q;
  logic [CNT_W-1:0] stall_d, flush_d, fwd_d, ret_d;

  assign id_valid_c = ID_Valid & IF_ID_Write;
  assign ex_dst_c   = EX_RegDst ? ID_EX_Rd : ID_EX_Rt;

  // Pipeline registers; a bubble zeroes control but register fields still load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_valid_q    <= 1'b0;
      EX_ALUSrc       <= 1'b0;
      EX_RegDst       <= 1'b0;
      EX_ALUOperation <= 3'b000;
      ID_EX_MemRead   <= 1'b0;
      idex_memwrite_q <= 1'b0;
      idex_memtoreg_q <= 1'b0;
      idex_regwrite_q <= 1'b0;
      ID_EX_Rs        <= '0;
      ID_EX_Rt        <= '0;
      ID_EX_Rd        <= '0;
      exmem_valid_q   <= 1'b0;
      EX_MEM_RegWrite <= 1'b0;
      EX_MEM_MemWrite <= 1'b0;
      EX_MEM_MemRead  <= 1'b0;
      EX_MEM_MemToReg <= 1'b0;
      EX_MEM_Rd       <= '0;
      memwb_valid_q   <= 1'b0;
      MEM_WB_RegWrite <= 1'b0;
      MEM_WB_MemToReg <= 1'b0;
      MEM_WB_Rd       <= '0;
    end else if (!Freeze) begin
      idex_valid_q    <= id_valid_c;
      EX_ALUSrc       <= id_valid_c & FinalALUSrc;
      EX_RegDst       <= id_valid_c & FinalRegDst;
      EX_ALUOperation <= id_valid_c ? FinalALUOperation : 3'b000;
      ID_EX_MemRead   <= id_valid_c & FinalMemRead;
      idex_memwrite_q <= id_valid_c & FinalMemWrite;
      idex_memtoreg_q <= id_valid_c & FinalMemToReg;
      idex_regwrite_q <= id_valid_c & FinalRegWrite;
      ID_EX_Rs        <= ID_Rs;
      ID_EX_Rt        <= ID_Rt;
      ID_EX_Rd        <= ID_Rd;
      exmem_valid_q   <= idex_valid_q;
      EX_MEM_RegWrite <= idex_valid_q & idex_regwrite_q & (ex_dst_c != '0);
      EX_MEM_MemWrite <= idex_valid_q & idex_memwrite_q;
      EX_MEM_MemRead  <= idex_valid_q & ID_EX_MemRead;
      EX_MEM_MemToReg <= idex_valid_q & idex_memtoreg_q;
      EX_MEM_Rd       <= ex_dst_c;
      memwb_valid_q   <= exmem_valid_q;
      MEM_WB_RegWrite <= exmem_valid_q & EX_MEM_RegWrite;
      MEM_WB_MemToReg <= exmem_valid_q & EX_MEM_MemToReg;
      MEM_WB_Rd       <= EX_MEM_Rd;
    end
  end

  // Counter next-state: clear beats increment, increments saturate.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    fwd_d   = fwd_q;
    ret_d   = ret_q;
    if (CntClear) begin
      stall_d = '0;
      flush_d = '0;
      fwd_d   = '0;
      ret_d   = '0;
    end else begin
      if (!IF_ID_Write && stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
      if (IF_Flush && flush_q != CNT_MAX)     flush_d = flush_q + CNT_W'(1);
      if (idex_valid_q && (ForwardA != 2'b00 || ForwardB != 2'b00) && fwd_q != CNT_MAX)
        fwd_d = fwd_q + CNT_W'(1);
      if (memwb_valid_q && ret_q != CNT_MAX)  ret_d = ret_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      fwd_q   <= '0;
      ret_q   <= '0;
    end else if (!Freeze) begin
      stall_q <= stall_d;
      flush_q <= flush_d;
      fwd_q   <= fwd_d;
      ret_q   <= ret_d;
    end
  end

  assign StallCount   = stall_q;
  assign FlushCount   = flush_q;
  assign FwdCount     = fwd_q;
  assign RetiredCount = ret_q;

endmodule
